apm_scan_ctrl: RTL and testbench
================================

# apm_scan_ctrl

Streaming scan controller for the approximate-pattern-matching datapath. It holds one programmed 16-bit pattern with four don't-care bit positions. It accepts a serial bit stream under valid/ready and slides a 16-bit window over it. For every stream position whose window matches, it reports that position, stalling the stream while a report is unconsumed.

## Interface
- POS_W, 16, width of scan length and match position
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- cfg_valid  in  1  config word present
- cfg_ready  out  1  high only in IDLE
- cfg_data  in  32  [15:0] pattern P, [19:16] k0, [23:20] k1, [27:24] k2, [31:28] k3 (don't-care bit indices)
- start  in  1  begin scan (sampled in IDLE only)
- scan_len  in  POS_W  number of stream bits in this scan, latched on start
- bit_valid  in  1  stream bit present
- bit_ready  out  1  controller accepts stream bit
- bit_data  in  1  stream bit
- match_valid  out  1  match report pending
- match_ready  in  1  consumer takes report
- match_pos  out  POS_W  index (0-based) of newest bit in matching window
- busy  out  1  state != IDLE
- done  out  1  one-cycle end-of-scan pulse

## Operation
- Config: cfg_valid && cfg_ready latches cfg_data into pattern register at the edge. Reset value 0, so bit 0 is don't-care after reset.
- Window W[15:0]: on each accepted bit, W <= {W[14:0], bit_data}. W[0] is newest, W[15] oldest. Cleared to 0 on start.
- Compare: match when, for every i in 0..15, W[i]==P[i] or i ∈ {k0,k1,k2,k3}. Duplicate indices are legal and give fewer than 4 don't-cares.
- Counter cnt (POS_W bits) holds bits accepted this scan. It is cleared on start.
- A window is eligible once cnt_after_accept >= 16.
- States:
  - IDLE: cfg_ready=1. If cfg_valid, accept config and ignore start in that cycle. Else on start, latch scan_len, clear cnt and W. Go to SCAN, or to DRAIN if scan_len==0.
  - SCAN: bit_ready = !match_valid || match_ready. On accept, shift W and increment cnt. When cnt reaches scan_len, go to DRAIN.
  - DRAIN: bit_ready=0. When !match_valid || match_ready, go to IDLE and assert done in the first IDLE cycle.
- Match output is a one-entry buffer with same-cycle handoff.
  - On the accepting edge, the shifted window is compared. If the window is eligible and matches, match_valid<=1 and match_pos<=cnt (the pre-increment value, i.e. newest index).
  - Otherwise, match_valid clears when match_ready is high.
- bit_valid outside SCAN is ignored. start while busy is ignored.
- scan_len < 16 never produces a match.
- The stream is 2^POS_W−1 bits max. cnt does not wrap within a scan.

## Timing
- Reset values: cfg_ready=1, bit_ready=0, match_valid=0, match_pos=0, busy=0, done=0. Pattern, W, cnt and state return to IDLE on rst_n low regardless of activity. A pending match is discarded and no done is issued.
- start sampled at edge E. busy=1 from E and bit_ready may be 1 from E.
- Match latency is 1: match_valid is high in the cycle after the edge that accepted the completing bit.
- Back-to-back: with match_ready tied high, one bit is accepted every cycle and every matching position is reported consecutively.
- Stall: match_valid && !match_ready forces bit_ready=0 the same cycle. No report is ever dropped or overwritten.
- Final bit accepted at edge F:
  - If no match is pending after F, or the pending match is consumed in the cycle after F, done is high in cycle F+2 and busy falls at the same edge.
  - Otherwise, done is delayed until the match is consumed.

## Configuration
- APM_WILDCARD_EN
  - Defined: k0..k3 mask compare as above.
  - Undefined: cfg_data[31:16] is ignored (the register may be omitted) and the compare is exact, W==P.
  - Timing and interface are unchanged in both cases.

## Test plan
- Exact hit with wildcard: cfg P=16'hA5C3, k0..k3=0, scan_len=16, stream equal to P with MSB first.
  - Required: match_valid one cycle after the 16th accept, match_pos=15, then done.
- Wildcards: P=16'h0000, k={1,5,9,15} (APM_WILDCARD_EN), stream has 1s at window bits 1,5,9,15 → match. Same stream with an extra 1 at bit 2 → no match, and done only.
- Sliding repeat: P=16'hFFFF, k=0, scan_len=20, stream all 1s, match_ready=1.
  - Required: five consecutive reports, match_pos=15..19, no bubbles on bit_ready.
- Backpressure: as above with match_ready=0 for 10 cycles after the first report.
  - Required: bit_ready=0 throughout, match_pos holds 15.
  - After release: remaining reports 16..19 are in order and none are lost.
- Boundaries:
  - scan_len=0 → done pulse with no bit accepted.
  - scan_len=15 → no match.
  - start together with cfg_valid → config taken, start ignored.
  - start during SCAN ignored.
- Reset mid-scan: assert rst_n low with match_valid=1.
  - Required: all outputs at reset values, no done, cfg_ready=1.
  - Pattern reads back 0 (next scan of 16 zeros matches).

Source files
------------

// File: rtl/apm_scan_if.sv
// apm_scan_if: config, stream, match-report and status signals of the scan controller
interface apm_scan_if #(parameter int POS_W = 16);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [31:0]      cfg_data;
    logic             start;
    logic [POS_W-1:0] scan_len;
    logic             bit_valid;
    logic             bit_ready;
    logic             bit_data;
    logic             match_valid;
    logic             match_ready;
    logic [POS_W-1:0] match_pos;
    logic             busy;
    logic             done;
    modport master (
        output cfg_valid, cfg_data, start, scan_len, bit_valid, bit_data, match_ready,
        input  cfg_ready, bit_ready, match_valid, match_pos, busy, done
    );
    modport slave (
        input  cfg_valid, cfg_data, start, scan_len, bit_valid, bit_data, match_ready,
        output cfg_ready, bit_ready, match_valid, match_pos, busy, done
    );
endinterface

// File: rtl/apm_scan_ctrl.sv
// apm_scan_ctrl: slides a 16-bit window over a serial stream and reports matching positions.
// Define APM_WILDCARD_EN to enable the four don't-care bit indices in cfg_data[31:16].
module apm_scan_ctrl #(
    parameter int POS_W = 16
) (
    input logic clk,
    input logic rst_n,
    apm_scan_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;
    state_t           state, state_nx;
    logic [15:0]      pat, win, win_nx, care;
    logic [POS_W-1:0] cnt, cnt_nx, len;
    logic             acc, hit, elig, drain_ok, cfg_take, start_take;
`ifdef APM_WILDCARD_EN
    logic [15:0]      kidx;
    always_comb begin
        care = '1;
        for (int i = 0; i < 4; i++) care[kidx[4*i +: 4]] = 1'b0;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) kidx <= '0;
        else if (cfg_take) kidx <= bus.cfg_data[31:16];
`else
    assign care = '1;
`endif
    // config wins over start when both arrive in IDLE
    assign cfg_take      = state == IDLE && bus.cfg_valid;
    assign start_take    = state == IDLE && !bus.cfg_valid && bus.start;
    assign bus.cfg_ready = state == IDLE;
    assign bus.busy      = state != IDLE;
    assign bus.bit_ready = state == SCAN && (!bus.match_valid || bus.match_ready);
    assign acc           = bus.bit_valid && bus.bit_ready;
    assign drain_ok      = !bus.match_valid || bus.match_ready;
    assign win_nx        = {win[14:0], bus.bit_data};
    assign cnt_nx        = cnt + 1'b1;
    assign elig          = cnt_nx >= POS_W'(16);
    assign hit           = ((win_nx ^ pat) & care) == 16'h0;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_take) state_nx = bus.scan_len == '0 ? DRAIN : SCAN;
            SCAN:    if (acc && cnt_nx == len) state_nx = DRAIN;
            DRAIN:   if (drain_ok) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            pat             <= '0;
            win             <= '0;
            cnt             <= '0;
            len             <= '0;
            bus.match_valid <= 1'b0;
            bus.match_pos   <= '0;
            bus.done        <= 1'b0;
        end else begin
            state    <= state_nx;
            bus.done <= state == DRAIN && drain_ok;
            if (cfg_take) pat <= bus.cfg_data[15:0];
            if (start_take) begin
                len <= bus.scan_len;
                cnt <= '0;
                win <= '0;
            end else if (acc) begin
                win <= win_nx;
                cnt <= cnt_nx;
            end
            // acceptance implies the buffer is empty or draining, so nothing is overwritten
            if (acc && elig && hit) begin
                bus.match_valid <= 1'b1;
                bus.match_pos   <= cnt;
            end else if (bus.match_ready) begin
                bus.match_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_apm_scan_ctrl.sv
// tb_apm_scan_ctrl: scoreboard bench; a bit-level model queues expected match positions on each accept.
module tb_apm_scan_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    apm_scan_if #(.POS_W(16)) bus();
    apm_scan_ctrl #(.POS_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;
    logic [15:0] mpat, mk, mwin;
    int mcnt, nacc, nrep, bubbles, done_tick, last_acc;
    int q[$];

`ifdef APM_WILDCARD_EN
    localparam int WC_N = 1;
`else
    localparam int WC_N = 0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic model_hit(input logic [15:0] w);
        logic wild;
        for (int i = 0; i < 16; i++) begin
            if (w[i] !== mpat[i]) begin
                wild = 1'b0;
`ifdef APM_WILDCARD_EN
                for (int j = 0; j < 4; j++) if (int'(mk[4*j +: 4]) == i) wild = 1'b1;
`endif
                if (!wild) return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    task automatic sample(input int c);
        logic acc;
        acc = bus.bit_valid && bus.bit_ready;
        if (bus.bit_valid && !bus.bit_ready) bubbles++;
        if (acc) begin
            mwin = {mwin[14:0], bus.bit_data};
            mcnt++;
            nacc++;
            last_acc = c;
            if (mcnt >= 16 && model_hit(mwin)) q.push_back(mcnt - 1);
        end
        if (bus.match_valid && bus.match_ready) begin
            nrep++;
            check("report_expected", q.size() > 0, 1);
            if (q.size() > 0) check("match_pos", bus.match_pos, q.pop_front());
        end
        if (bus.done && done_tick < 0) done_tick = c;
    endtask

    task automatic cfg(input logic [15:0] p, input logic [15:0] k);
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = {k, p};
        #1;
        check("cfg_ready", bus.cfg_ready, 1);
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        mpat = p;
        mk   = k;
    endtask

    task automatic run_scan(input string tag, input int len, input logic [63:0] s,
                            input int stall, input int exp_n);
        int stall_left;
        logic stall_pending;
        nacc = 0; nrep = 0; bubbles = 0; done_tick = -1; last_acc = -1;
        mwin = '0; mcnt = 0; stall_left = 0; stall_pending = stall > 0;
        bus.scan_len = 16'(len);
        bus.start = 1'b1;
        #1;
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, "_busy"}, bus.busy, 1);
        for (int c = 0; c < 300 && done_tick < 0; c++) begin
            bus.bit_valid = nacc < len;
            bus.bit_data  = nacc < len ? s[len - 1 - nacc] : 1'b0;
            bus.start     = c == 3;
            bus.scan_len  = 16'd1;
            if (stall_pending && bus.match_valid) begin
                stall_left = stall;
                stall_pending = 1'b0;
            end
            bus.match_ready = stall_left == 0;
            #1;
            if (stall_left > 0) begin
                check({tag, "_stall_ready"}, bus.bit_ready, 0);
                check({tag, "_stall_pos"}, bus.match_pos, q.size() > 0 ? q[0] : -1);
                stall_left--;
            end
            sample(c);
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.bit_valid = 1'b0;
        bus.match_ready = 1'b1;
        check({tag, "_done_seen"}, done_tick >= 0, 1);
        check({tag, "_accepted"}, nacc, len);
        check({tag, "_reports"}, nrep, exp_n);
        check({tag, "_queue_empty"}, q.size(), 0);
        check({tag, "_bubbles"}, bubbles, stall > 0 ? stall : 0);
        if (len > 0) check({tag, "_done_lat"}, done_tick - last_acc, 2);
        else check({tag, "_done_lat"}, done_tick, 1);
        #1;
        check({tag, "_done_pulse"}, bus.done, 0);
        check({tag, "_idle"}, bus.busy, 0);
    endtask

    initial begin
        bus.cfg_valid = 1'b0; bus.cfg_data = '0; bus.start = 1'b0; bus.scan_len = '0;
        bus.bit_valid = 1'b0; bus.bit_data = 1'b0; bus.match_ready = 1'b1;
        mpat = '0; mk = '0; mwin = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_cfg_ready", bus.cfg_ready, 1);
        check("rst_bit_ready", bus.bit_ready, 0);
        check("rst_match_valid", bus.match_valid, 0);
        check("rst_match_pos", bus.match_pos, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        cfg(16'hA5C3, 16'h0000);
        run_scan("hit", 16, 64'hA5C3, 0, 1);

        cfg(16'h0000, {4'd15, 4'd9, 4'd5, 4'd1});
        run_scan("wild", 16, 64'h8222, 0, WC_N);
        run_scan("wild_miss", 16, 64'h8226, 0, 0);

        cfg(16'hFFFF, 16'h0000);
        run_scan("slide", 20, 64'hFFFFF, 0, 5);
        run_scan("bp", 20, 64'hFFFFF, 10, 5);
        run_scan("len0", 0, 64'h0, 0, 0);
        run_scan("len15", 15, 64'h7FFF, 0, 0);

        bus.cfg_valid = 1'b1; bus.cfg_data = {16'h0000, 16'hA5C3};
        bus.start = 1'b1; bus.scan_len = 16'd16;
        #1;
        @(negedge clk);
        bus.cfg_valid = 1'b0; bus.start = 1'b0;
        mpat = 16'hA5C3; mk = '0;
        #1;
        check("cfg_start_busy", bus.busy, 0);
        run_scan("cfg_start", 16, 64'hA5C3, 0, 1);

        cfg(16'hFFFF, 16'h0000);
        bus.scan_len = 16'd20;
        bus.start = 1'b1;
        #1;
        @(negedge clk);
        bus.start = 1'b0; bus.match_ready = 1'b0; bus.bit_valid = 1'b1; bus.bit_data = 1'b1;
        for (int c = 0; c < 40 && !bus.match_valid; c++) @(negedge clk);
        check("rst_pre_match", bus.match_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_cfg_ready", bus.cfg_ready, 1);
        check("mid_rst_bit_ready", bus.bit_ready, 0);
        check("mid_rst_match_valid", bus.match_valid, 0);
        check("mid_rst_match_pos", bus.match_pos, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_done", bus.done, 0);
        bus.bit_valid = 1'b0; bus.match_ready = 1'b1;
        q.delete(); mpat = '0; mk = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("post_rst_no_done", bus.done, 0);
            @(negedge clk);
        end
        run_scan("rst_zero", 16, 64'h0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
